multicycle_ctrl: RTL and testbench

//  Moore FSM controller that sequences the multicycle RV32I datapath.

---
 rtl/multicycle_ctrl_pkg.sv | 57 +++++
 rtl/multicycle_ctrl_alu_dec.sv | 29 ++
 rtl/multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes, ALU codes and
// datapath select codes.
package multicycle_ctrl_pkg;

   localparam logic [3:0] StFetch    = 4'd0;
   localparam logic [3:0] StDecode   = 4'd1;
   localparam logic [3:0] StMemAdr   = 4'd2;
   localparam logic [3:0] StMemRead  = 4'd3;
   localparam logic [3:0] StMemWb    = 4'd4;
   localparam logic [3:0] StMemWrite = 4'd5;
   localparam logic [3:0] StExecR    = 4'd6;
   localparam logic [3:0] StExecI    = 4'd7;
   localparam logic [3:0] StAluWb    = 4'd8;
   localparam logic [3:0] StBeq      = 4'd9;
   localparam logic [3:0] StJal      = 4'd10;
   localparam logic [3:0] StError    = 4'd11;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIType  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   localparam logic [1:0] AluOpAdd  = 2'b00;
   localparam logic [1:0] AluOpSub  = 2'b01;
   localparam logic [1:0] AluOpFunc = 2'b10;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluSlt = 3'b101;

   localparam logic [1:0] ResAluOut    = 2'b00;
   localparam logic [1:0] ResData      = 2'b01;
   localparam logic [1:0] ResAluResult = 2'b10;

   localparam logic [1:0] SrcAPc    = 2'b00;
   localparam logic [1:0] SrcAOldPc = 2'b01;
   localparam logic [1:0] SrcARs1   = 2'b10;

   localparam logic [1:0] SrcBRs2  = 2'b00;
   localparam logic [1:0] SrcBImm  = 2'b01;
   localparam logic [1:0] SrcBFour = 2'b10;

   localparam logic [1:0] ImmI = 2'b00;
   localparam logic [1:0] ImmS = 2'b01;
   localparam logic [1:0] ImmB = 2'b10;
   localparam logic [1:0] ImmJ = 2'b11;

   // Only these funct3 values are implemented for register/immediate ALU ops.
   function automatic logic funct3_legal(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// Combinational ALU decoder: maps ALUOp and instruction fields to ALUControl.
module multicycle_ctrl_alu_dec
   import multicycle_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       op_b5,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = AluAdd;
      case (alu_op)
         AluOpSub: alu_control = AluSub;
         AluOpFunc: begin
            case (funct3)
               3'b000:  alu_control = (op_b5 && funct7b5) ? AluSub : AluAdd;
               3'b010:  alu_control = AluSlt;
               3'b110:  alu_control = AluOr;
               3'b111:  alu_control = AluAnd;
               default: alu_control = AluAdd;
            endcase
         end
         default: alu_control = AluAdd;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the multicycle RV32I datapath, with a memory-ready handshake and a
// watchdog that traps to ERROR when memory stalls too long.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Illegal
);

   localparam int unsigned CntW = $clog2(MEM_TIMEOUT);

   logic [3:0]      state_q, state_d, out_state;
   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic            mem_wait, timeout;
   logic [1:0]      alu_op;

   assign mem_wait = ((state_q == StFetch) || (state_q == StMemRead) ||
                      (state_q == StMemWrite)) && !MemReady;
   assign timeout  = mem_wait && (wait_cnt_q == CntW'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:    if (MemReady) state_d = StDecode;
         StDecode: begin
            case (op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRType:         state_d = funct3_legal(funct3) ? StExecR : StError;
               OpIType:         state_d = funct3_legal(funct3) ? StExecI : StError;
               OpBranch:        state_d = StBeq;
               OpJal:           state_d = StJal;
               default:         state_d = StError;
            endcase
         end
         StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
         StMemRead:  if (MemReady) state_d = StMemWb;
         StMemWb:    state_d = StFetch;
         StMemWrite: if (MemReady) state_d = StFetch;
         StExecR:    state_d = StAluWb;
         StExecI:    state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StBeq:      state_d = StFetch;
         StJal:      state_d = StAluWb;
         StError:    state_d = StError;
         default:    state_d = StError;
      endcase
      if (timeout) state_d = StError;
   end

   // Counter only runs while stalled in the same memory state; any transition clears it.
   assign wait_cnt_d = (mem_wait && (state_d == state_q)) ? wait_cnt_q + CntW'(1) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StFetch;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // During reset the outputs look like FETCH with every enable suppressed.
   assign out_state = reset ? StFetch : state_q;

   always_comb begin
      MemReq    = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = ResAluOut;
      ALUSrcA   = SrcAPc;
      ALUSrcB   = SrcBRs2;
      alu_op    = AluOpAdd;
      Illegal   = 1'b0;
      case (out_state)
         StFetch: begin
            MemReq    = 1'b1;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
            ALUSrcB   = SrcBFour;
            ResultSrc = ResAluResult;
         end
         StDecode: begin
            ALUSrcA = SrcAOldPc;
            ALUSrcB = SrcBImm;
         end
         StMemAdr: begin
            ALUSrcA = SrcARs1;
            ALUSrcB = SrcBImm;
         end
         StMemRead: begin
            MemReq = 1'b1;
            AdrSrc = 1'b1;
         end
         StMemWb: begin
            ResultSrc = ResData;
            RegWrite  = 1'b1;
         end
         StMemWrite: begin
            MemReq   = 1'b1;
            MemWrite = 1'b1;
            AdrSrc   = 1'b1;
         end
         StExecR: begin
            ALUSrcA = SrcARs1;
            alu_op  = AluOpFunc;
         end
         StExecI: begin
            ALUSrcA = SrcARs1;
            ALUSrcB = SrcBImm;
            alu_op  = AluOpFunc;
         end
         StAluWb:  RegWrite = 1'b1;
         StBeq: begin
            ALUSrcA = SrcARs1;
            alu_op  = AluOpSub;
            PCWrite = Zero;
         end
         StJal: begin
            ALUSrcA = SrcAOldPc;
            ALUSrcB = SrcBFour;
            PCWrite = 1'b1;
         end
         StError:  Illegal = 1'b1;
         default:  Illegal = 1'b1;
      endcase
      if (reset) begin
         MemReq   = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
      end
   end

   always_comb begin
      case (op)
         OpStore:  ImmSrc = ImmS;
         OpBranch: ImmSrc = ImmB;
         OpJal:    ImmSrc = ImmJ;
         default:  ImmSrc = ImmI;
      endcase
   end

   multicycle_ctrl_alu_dec u_alu_dec (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .op_b5       (op[5]),
      .funct7b5    (funct7b5),
      .alu_control (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, the memory watchdog,
// illegal decodes and reset during a store.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Zero, MemReady;
   logic       MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [17:0] outs;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .MemReq     (MemReq),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .Illegal    (Illegal)
   );

   assign outs = {MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};

   // Field order: MemReq AdrSrc MemWrite IRWrite PCWrite RegWrite Res A B Imm ALU Illegal
   function automatic logic [17:0] pk(input logic mreq, input logic adr, input logic mw,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] res, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] imm,
                                      input logic [2:0] alu, input logic ill);
      return {mreq, adr, mw, irw, pcw, rw, res, a, b, imm, alu, ill};
   endfunction

   function automatic logic [17:0] fetch_v(input logic rdy, input logic [1:0] imm);
      return pk(1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
   endfunction

   function automatic logic [17:0] err_v(input logic [1:0] imm);
      return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [17:0] exp);
      #1;
      checks++;
      assert (outs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, outs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
      Zero = 1'b0; MemReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));

      // R-type sub
      reset = 1'b0;
      chk("r_fetch", fetch_v(1, 2'b00));
      step(); chk("r_decode", pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
      step(); chk("r_execr", pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0));
      step(); chk("r_aluwb", pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      step(); chk("r_fetch2", fetch_v(1, 2'b00));

      // I-type ori
      op = 7'b0010011; funct3 = 3'b110; funct7b5 = 1'b0;
      step(); chk("i_decode", pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
      step(); chk("i_execi", pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 0));
      step(); chk("i_aluwb", pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));

      // lw with a 3-cycle memory stall
      step(); op = 7'b0000011; funct3 = 3'b010;
      chk("lw_fetch", fetch_v(1, 2'b00));
      step(); step();
      chk("lw_memadr", pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
      step(); MemReady = 1'b0;
      chk("lw_memread_w0", pk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      for (int i = 0; i < 2; i++) begin
         step();
         chk("lw_memread_wn", pk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      end
      step(); MemReady = 1'b1;
      chk("lw_memread_rdy", pk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      step(); chk("lw_memwb", pk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));

      // beq
      step(); op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
      chk("beq_fetch", fetch_v(1, 2'b10));
      step(); step();
      chk("beq_taken", pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
      Zero = 1'b0;
      chk("beq_not_taken", pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));

      // jal
      step(); op = 7'b1101111;
      chk("jal_fetch", fetch_v(1, 2'b11));
      step(); step();
      chk("jal_jal", pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
      step(); chk("jal_aluwb", pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0));

      // Watchdog: MemReady low from the first FETCH cycle
      step(); op = 7'b0110011; funct3 = 3'b000; MemReady = 1'b0;
      chk("wd_fetch_1", fetch_v(0, 2'b00));
      for (int i = 2; i <= 16; i++) begin
         step(); chk("wd_fetch_n", fetch_v(0, 2'b00));
      end
      step(); chk("wd_error_17", err_v(2'b00));
      MemReady = 1'b1;
      step(); step(); chk("wd_error_sticky", err_v(2'b00));
      do_reset(); chk("wd_after_reset", fetch_v(1, 2'b00));

      // Unknown opcode
      op = 7'b1111111;
      step(); step(); chk("badop_error", err_v(2'b00));
      do_reset();

      // Unsupported funct3 on an R-type
      op = 7'b0110011; funct3 = 3'b001;
      step(); step(); chk("badf3_error", err_v(2'b00));
      do_reset();

      // sw interrupted by reset while waiting in MEMWRITE
      op = 7'b0100011; funct3 = 3'b010;
      chk("sw_fetch", fetch_v(1, 2'b01));
      step(); step(); step(); MemReady = 1'b0;
      chk("sw_memwrite", pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
      reset = 1'b1;
      chk("sw_reset_same", pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));
      step(); reset = 1'b0;
      chk("sw_reset_fetch", fetch_v(0, 2'b01));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
